// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads opcode/operand words from the registered IRAM,
// presents one instruction bundle at a time to the core and stalls on branches.
module instr_fetch_unit #(
  parameter int unsigned         DATA_W   = 16,
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_has_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_resolve,
  input  logic              branch_taken,
  output logic              busy,
  output logic              halted
);

  localparam logic [DATA_W-1:0] OP_LDAC  = DATA_W'(5);
  localparam logic [DATA_W-1:0] OP_STAC  = DATA_W'(7);
  localparam logic [DATA_W-1:0] OP_LDA   = DATA_W'(9);
  localparam logic [DATA_W-1:0] OP_LDB   = DATA_W'(14);
  localparam logic [DATA_W-1:0] OP_LDC   = DATA_W'(19);
  localparam logic [DATA_W-1:0] OP_STC   = DATA_W'(24);
  localparam logic [DATA_W-1:0] OP_JUMP  = DATA_W'(46);
  localparam logic [DATA_W-1:0] OP_JPNZ  = DATA_W'(48);
  localparam logic [DATA_W-1:0] OP_ENDOP = DATA_W'(51);
  localparam logic [DATA_W-1:0] OP_JPPZ  = DATA_W'(62);

  typedef enum logic [2:0] {
    IDLE, WAIT_OP, CAP_OP, WAIT_ARG, CAP_ARG, PRESENT, BRANCH, HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] iram_addr_q, iram_addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              has_op_q, has_op_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] next_pc;

  function automatic logic is_two_word(input logic [DATA_W-1:0] op);
    return op inside {OP_LDAC, OP_STAC, OP_LDA, OP_LDB, OP_LDC, OP_STC,
                      OP_JUMP, OP_JPNZ, OP_JPPZ};
  endfunction

  function automatic logic is_branch(input logic [DATA_W-1:0] op);
    return op inside {OP_JUMP, OP_JPNZ, OP_JPPZ};
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iram_addr_d = iram_addr_q;
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    has_op_d    = has_op_q;
    ipc_d       = ipc_q;
    next_pc     = pc_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d        = RESET_PC;
          iram_addr_d = RESET_PC;
          state_d     = WAIT_OP;
        end
      end
      WAIT_OP: state_d = CAP_OP;
      CAP_OP: begin
        opcode_d = iram_data;
        ipc_d    = pc_q;
        if (is_two_word(iram_data)) begin
          iram_addr_d = pc_q + ADDR_W'(1);
          state_d     = WAIT_ARG;
        end else begin
          operand_d = '0;
          has_op_d  = 1'b0;
          valid_d   = 1'b1;
          state_d   = PRESENT;
        end
      end
      WAIT_ARG: state_d = CAP_ARG;
      CAP_ARG: begin
        operand_d = iram_data;
        has_op_d  = 1'b1;
        valid_d   = 1'b1;
        state_d   = PRESENT;
      end
      PRESENT: begin
        // branch_resolve is deliberately ignored here, even on the transfer edge
        if (instr_ready) begin
          valid_d = 1'b0;
          if (opcode_q == OP_ENDOP) begin
            state_d = HALT;
          end else if (is_branch(opcode_q)) begin
            state_d = BRANCH;
          end else begin
            next_pc     = ipc_q + (has_op_q ? ADDR_W'(2) : ADDR_W'(1));
            pc_d        = next_pc;
            iram_addr_d = next_pc;
            state_d     = WAIT_OP;
          end
        end
      end
      BRANCH: begin
        if (branch_resolve) begin
          next_pc     = branch_taken ? operand_q[ADDR_W-1:0] : ipc_q + ADDR_W'(2);
          pc_d        = next_pc;
          iram_addr_d = next_pc;
          state_d     = WAIT_OP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      iram_addr_q <= RESET_PC;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      operand_q   <= '0;
      has_op_q    <= 1'b0;
      ipc_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iram_addr_q <= iram_addr_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      operand_q   <= operand_d;
      has_op_q    <= has_op_d;
      ipc_q       <= ipc_d;
    end
  end

  assign iram_addr         = iram_addr_q;
  assign instr_valid       = valid_q;
  assign instr_opcode      = opcode_q;
  assign instr_operand     = operand_q;
  assign instr_has_operand = has_op_q;
  assign instr_pc          = ipc_q;
  assign busy              = (state_q != IDLE) && (state_q != HALT);
  assign halted            = (state_q == HALT);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Read-side master for the 16-bit instruction RAM: drives the RAM address and captures its registered data_out (1-cycle read latency).
- Assembles single-word and two-word (opcode + operand) instructions and hands them to the core control unit over a valid/ready handshake.
- Holds after each branch until the core resolves it. Halts after ENDOP is accepted.
- One instance per core, sits between the IRAM and the core control FSM.

Parameters:
- DATA_W, 16, instruction/operand word width.
- ADDR_W, 16, program-counter and IRAM address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC loaded on reset and on every start.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin fetching at RESET_PC; honoured only in IDLE or HALT
- iram_addr  out  ADDR_W  registered address to IRAM
- iram_data  in  DATA_W  IRAM data_out; valid the cycle after IRAM samples iram_addr
- instr_valid  out  1  instruction bundle valid
- instr_ready  in  1  core accepts bundle
- instr_opcode  out  DATA_W  opcode word
- instr_operand  out  DATA_W  operand word; 0 when none
- instr_has_operand  out  1  bundle is a two-word instruction
- instr_pc  out  ADDR_W  address of the opcode word
- branch_resolve  in  1  one-cycle pulse, branch outcome known
- branch_taken  in  1  sampled with branch_resolve
- busy  out  1  high in every state except IDLE/HALT
- halted  out  1  high in HALT

Behaviour:
- Reset (async, immediate): state IDLE. pc=RESET_PC, iram_addr=RESET_PC. instr_valid=0, instr_opcode=0, instr_operand=0, instr_has_operand=0, instr_pc=0, busy=0, halted=0. Reset mid-fetch discards any partial bundle.
- Operand-bearing opcodes: LDAC=5, STAC=7, LDA=9, LDB=14, LDC=19, STC=24, JUMP=46, JPNZ=48, JPPZ=62. Every other value is single-word, including LDDAC=55, STDAC=59 and unknown codes.
- Branch opcodes: JUMP, JPNZ, JPPZ. ENDOP=51.
- States: IDLE, WAIT_OP, CAP_OP, WAIT_ARG, CAP_ARG, PRESENT, BRANCH, HALT.
- Issue edge: any edge that enters WAIT_OP also loads iram_addr<=pc.
- IDLE/HALT + start: pc<=RESET_PC, iram_addr<=RESET_PC, go WAIT_OP.
- WAIT_OP -> CAP_OP unconditionally; IRAM latches the word.
- CAP_OP:
  - Latch instr_opcode=iram_data and instr_pc=pc.
  - If operand-bearing: iram_addr<=pc+1, go WAIT_ARG.
  - Else: instr_operand=0, has_operand=0, instr_valid<=1, go PRESENT.
- WAIT_ARG -> CAP_ARG. CAP_ARG: latch instr_operand=iram_data, has_operand=1, instr_valid<=1, go PRESENT.
- Latency from issue edge: single-word valid after 2nd edge; two-word valid after 4th edge. Steady-state throughput: 3 cycles per single-word instruction, 5 per two-word.
- PRESENT: all instr_* outputs held stable while instr_valid && !instr_ready.
- Transfer on the edge where instr_valid && instr_ready; instr_valid<=0 at that edge. Next state depends on the opcode:
  - ENDOP: go HALT.
  - Branch: go BRANCH.
  - Else: pc<=instr_pc+1 (single) or +2 (two-word), issue, go WAIT_OP in the same edge.
- BRANCH: wait for branch_resolve. On resolve, pc<=branch_taken ? instr_operand[ADDR_W-1:0] : instr_pc+2, issue, go WAIT_OP.
- branch_resolve in any state other than BRANCH is ignored. start outside IDLE/HALT is ignored.
- branch_resolve arriving on the same edge as the branch transfer is ignored; the core must pulse it at least one cycle later.
- pc, pc+1 and pc+2 wrap modulo 2^ADDR_W.
- busy=1 in WAIT_OP..BRANCH; halted=1 only in HALT.

Test Plan:
- Fetch single-word instruction: ram[0]=35 (CLAC), ram[1]=51 (ENDOP); pulse start → bundle {opcode 35, pc 0, has_operand 0, operand 0} valid after 2 edges. Then {51, pc 1}. After accept, halted=1, busy=0, iram_addr stays 1.
- Fetch two-word instruction: ram[0]=5, ram[1]=7, ram[2]=51 → {opcode 5, operand 7, has_operand 1, pc 0} valid 4 edges after start. The next bundle has pc 2.
- Backpressure: hold instr_ready=0 for 5 cycles while a bundle is valid → all instr_* and iram_addr unchanged. Raise ready → exactly one transfer.
- JPNZ at address 160 with operand 48, resolved taken → next instr_pc 48. Same program resolved not-taken → next instr_pc 162. A resolve pulse while in PRESENT has no effect.
- Assert rst during WAIT_ARG → outputs return to reset values without waiting for a clock. No instr_valid appears until a later start.
- RESET_PC=16'hFFFF with a single-word opcode at 0xFFFF → next bundle instr_pc=0x0000 (wrap).
